// File: rtl/polynomial_pkg.sv
// rtl/polynomial_pkg.sv - shared float and tap-writer types for the polynomial estimator
package polynomial_pkg;

    localparam int C_FP_DWIDTH = 32;

    typedef logic [C_FP_DWIDTH-1:0] float_t;

    localparam float_t C_FP_ZERO = '0;

    typedef enum logic [1:0] {
        SM_LOAD      = 2'd0,
        SM_DISCARD   = 2'd1,
        SM_WAIT_SWAP = 2'd2
    } state_t;

endpackage

// File: rtl/polynomial_tap_bank.sv
// rtl/polynomial_tap_bank.sv - shadow/active tap register banks with atomic commit
module polynomial_tap_bank
    import polynomial_pkg::*;
#(
    parameter int G_POLY_ORDER = 5,
    localparam int IW = $clog2(G_POLY_ORDER)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  float_t        wr_data_i,
    input  logic          commit_i,
    output float_t        active_o [G_POLY_ORDER]
);

    float_t shadow_q [G_POLY_ORDER];
    float_t active_q [G_POLY_ORDER];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < G_POLY_ORDER; i++) begin
                shadow_q[i] <= C_FP_ZERO;
            end
        end else if (wr_en_i) begin
            shadow_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Whole-bank copy in one edge so the estimator never sees a mixed set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < G_POLY_ORDER; i++) begin
                active_q[i] <= C_FP_ZERO;
            end
        end else if (commit_i) begin
            active_q <= shadow_q;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/polynomial_tap_writer.sv
// rtl/polynomial_tap_writer.sv - framed tap loader that commits complete sets while the estimator is idle
module polynomial_tap_writer
    import polynomial_pkg::*;
#(
    parameter int G_POLY_ORDER = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  float_t      tap_din,
    input  logic        tap_din_valid,
    input  logic        tap_din_last,
    output logic        tap_din_ready,
    input  logic        swap_allow,
    output float_t      taps_out [G_POLY_ORDER],
    output logic        taps_update,
    output logic        err_short,
    output logic        err_long,
    output logic [15:0] sets_loaded
);

    localparam int            IW       = $clog2(G_POLY_ORDER);
    localparam logic [IW-1:0] LAST_IDX = IW'(G_POLY_ORDER - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ready_q, ready_d;
    logic          upd_q, upd_d;
    logic          es_q, es_d;
    logic          el_q, el_d;
    logic [15:0]   sets_q, sets_d;
    logic          wr_en;
    logic          commit;
    logic          xfer;

    assign xfer = tap_din_valid & ready_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        upd_d   = 1'b0;
        es_d    = 1'b0;
        el_d    = 1'b0;
        sets_d  = sets_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        if (!enable) begin
            state_d = SM_LOAD;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                SM_LOAD: begin
                    if (xfer) begin
                        wr_en = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            if (tap_din_last) begin
                                state_d = SM_WAIT_SWAP;
                            end else begin
                                el_d    = 1'b1;
                                state_d = SM_DISCARD;
                            end
                        end else if (tap_din_last) begin
                            es_d  = 1'b1;
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                SM_DISCARD: begin
                    idx_d = '0;
                    if (xfer && tap_din_last) begin
                        state_d = SM_LOAD;
                    end
                end
                SM_WAIT_SWAP: begin
                    if (swap_allow) begin
                        commit  = 1'b1;
                        upd_d   = 1'b1;
                        sets_d  = sets_q + 16'd1;
                        idx_d   = '0;
                        state_d = SM_LOAD;
                    end
                end
                default: begin
                    state_d = SM_LOAD;
                    idx_d   = '0;
                end
            endcase
        end
        // Ready is registered from the next state so it drops the cycle the set completes.
        ready_d = enable && (state_d != SM_WAIT_SWAP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SM_LOAD;
            idx_q   <= '0;
            ready_q <= 1'b0;
            upd_q   <= 1'b0;
            es_q    <= 1'b0;
            el_q    <= 1'b0;
            sets_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            upd_q   <= upd_d;
            es_q    <= es_d;
            el_q    <= el_d;
            sets_q  <= sets_d;
        end
    end

    polynomial_tap_bank #(
        .G_POLY_ORDER (G_POLY_ORDER)
    ) u_bank (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_data_i (tap_din),
        .commit_i  (commit),
        .active_o  (taps_out)
    );

    assign tap_din_ready = ready_q;
    assign taps_update   = upd_q;
    assign err_short     = es_q;
    assign err_long      = el_q;
    assign sets_loaded   = sets_q;

endmodule

// File: tb/tb_polynomial_tap_writer.sv
// tb/tb_polynomial_tap_writer.sv - self-checking bench for polynomial_tap_writer
module tb_polynomial_tap_writer;
    import polynomial_pkg::*;

    localparam int N = 5;

    logic        clk;
    logic        reset;
    logic        enable;
    float_t      tap_din;
    logic        tap_din_valid;
    logic        tap_din_last;
    logic        tap_din_ready;
    logic        swap_allow;
    float_t      taps_out [N];
    logic        taps_update;
    logic        err_short;
    logic        err_long;
    logic [15:0] sets_loaded;

    polynomial_tap_writer #(.G_POLY_ORDER(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .tap_din       (tap_din),
        .tap_din_valid (tap_din_valid),
        .tap_din_last  (tap_din_last),
        .tap_din_ready (tap_din_ready),
        .swap_allow    (swap_allow),
        .taps_out      (taps_out),
        .taps_update   (taps_update),
        .err_short     (err_short),
        .err_long      (err_long),
        .sets_loaded   (sets_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_mis = 0;
    float_t exp_bank [N];
    float_t pend_bank [N];
    int     exp_sets = 0;
    float_t fdata [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), taps_out[i], exp_bank[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame of len taps from fdata; last on the final tap. Checks error pulses after each transfer.
    task automatic send_frame(input int len);
        int w;
        for (int i = 0; i < len; i++) begin
            tap_din       = fdata[i];
            tap_din_valid = 1'b1;
            tap_din_last  = (i == len - 1);
            w = 0;
            while (!tap_din_ready && w < 50) begin
                tick();
                w++;
            end
            chk("ready_before_xfer", {31'd0, tap_din_ready}, 32'd1);
            tick();
            chk("err_short", {31'd0, err_short}, {31'd0, (i == len - 1) && (len < N)});
            chk("err_long",  {31'd0, err_long},  {31'd0, (i == N - 1) && (len > N)});
        end
        tap_din_valid = 1'b0;
        tap_din_last  = 1'b0;
        if (len == N) begin
            for (int i = 0; i < N; i++) pend_bank[i] = fdata[i];
            chk("ready_in_wait", {31'd0, tap_din_ready}, 32'd0);
        end
    endtask

    task automatic hold_wait(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            chk("hold_ready", {31'd0, tap_din_ready}, 32'd0);
            chk("hold_update", {31'd0, taps_update}, 32'd0);
        end
        chk_bank("hold_taps");
    endtask

    task automatic do_commit();
        swap_allow = 1'b1;
        tick();
        swap_allow = 1'b0;
        for (int i = 0; i < N; i++) exp_bank[i] = pend_bank[i];
        exp_sets = (exp_sets + 1) % 65536;
        chk_bank("commit_taps");
        chk("commit_update", {31'd0, taps_update}, 32'd1);
        chk("commit_sets", {16'd0, sets_loaded}, exp_sets);
        chk("commit_ready", {31'd0, tap_din_ready}, 32'd1);
        tick();
        chk("update_pulse_end", {31'd0, taps_update}, 32'd0);
    endtask

    task automatic rand_frame_data();
        for (int i = 0; i < 16; i++) fdata[i] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        reset = 1'b0;
        enable = 1'b1;
        tap_din = '0;
        tap_din_valid = 1'b0;
        tap_din_last = 1'b0;
        swap_allow = 1'b0;
        for (int i = 0; i < N; i++) exp_bank[i] = C_FP_ZERO;

        // reset state
        tick(); tick();
        chk_bank("reset_taps");
        chk("reset_ready", {31'd0, tap_din_ready}, 32'd0);
        chk("reset_sets", {16'd0, sets_loaded}, 32'd0);
        chk("reset_update", {31'd0, taps_update}, 32'd0);
        reset = 1'b1;
        tick();
        chk("ready_after_release", {31'd0, tap_din_ready}, 32'd1);

        // nominal load with swap_allow already high
        fdata[0] = 32'h3F800000; fdata[1] = 32'h40000000; fdata[2] = 32'h40400000;
        fdata[3] = 32'h40800000; fdata[4] = 32'h40A00000;
        swap_allow = 1'b1;
        send_frame(N);
        chk_bank("nominal_not_yet");
        do_commit();

        // held swap for 10 cycles
        rand_frame_data();
        send_frame(N);
        hold_wait(10);
        do_commit();

        // short set then a set of 8.0
        rand_frame_data();
        send_frame(3);
        chk_bank("short_no_commit");
        for (int i = 0; i < N; i++) fdata[i] = 32'h41000000;
        send_frame(N);
        do_commit();

        // long set: 7 taps
        rand_frame_data();
        send_frame(7);
        tick();
        chk_bank("long_no_commit");
        chk("long_sets", {16'd0, sets_loaded}, exp_sets);
        rand_frame_data();
        send_frame(N);
        do_commit();

        // enable low while waiting for swap
        rand_frame_data();
        send_frame(N);
        enable = 1'b0;
        tick();
        swap_allow = 1'b1;
        tick(); tick();
        chk_bank("disable_taps_kept");
        chk("disable_update", {31'd0, taps_update}, 32'd0);
        chk("disable_ready", {31'd0, tap_din_ready}, 32'd0);
        chk("disable_sets", {16'd0, sets_loaded}, exp_sets);
        swap_allow = 1'b0;
        enable = 1'b1;
        tick();
        chk("reenable_ready", {31'd0, tap_din_ready}, 32'd1);
        rand_frame_data();
        send_frame(N);
        do_commit();

        // random frames with random swap delays
        for (int k = 0; k < 30; k++) begin
            len = $urandom_range(1, 8);
            rand_frame_data();
            send_frame(len);
            if (len == N) begin
                hold_wait($urandom_range(0, 4));
                do_commit();
            end else begin
                chk_bank("rand_no_commit");
            end
        end

        // async reset mid-set
        rand_frame_data();
        tap_din = fdata[0]; tap_din_valid = 1'b1; tap_din_last = 1'b0;
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) exp_bank[i] = C_FP_ZERO;
        exp_sets = 0;
        chk_bank("async_reset_taps");
        chk("async_reset_sets", {16'd0, sets_loaded}, 32'd0);
        chk("async_reset_ready", {31'd0, tap_din_ready}, 32'd0);
        tap_din_valid = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        chk("ready_after_async", {31'd0, tap_din_ready}, 32'd1);
        rand_frame_data();
        send_frame(N);
        do_commit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/polynomial_tap_writer.md
# polynomial_tap_writer

Coefficient-side counterpart of the polynomial estimator. It accepts IEEE-754 single-precision polynomial taps over a valid/ready stream into a shadow bank. Once a complete, correctly framed set has arrived, it commits the set atomically to an active bank that the estimator reads, but only while the estimator reports it is idle. The estimator therefore never evaluates with a partially updated tap set.

## Interface
- G_POLY_ORDER, 5: taps per set; tap index 0 holds the constant term. Range 2..255.
- C_FP_DWIDTH, 32 (localparam): float width.

- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- enable  in  1  synchronous soft clear when 0.
- tap_din  in  32  coefficient, float.
- tap_din_valid  in  1  coefficient valid.
- tap_din_last  in  1  marks the final coefficient of a set.
- tap_din_ready  out  1  writer can accept a coefficient.
- swap_allow  in  1  estimator idle; a commit is permitted this cycle.
- taps_out  out  G_POLY_ORDER x 32  active bank, unpacked array of float_t, index 0..G_POLY_ORDER-1.
- taps_update  out  1  one-cycle pulse: active bank changed.
- err_short  out  1  one-cycle pulse: last arrived before index G_POLY_ORDER-1.
- err_long  out  1  one-cycle pulse: index G_POLY_ORDER-1 accepted without last.
- sets_loaded  out  16  count of committed sets; wraps at 16'hFFFF to 0.

## Operation
- Reset values:
  - taps_out all 32'h00000000 (+0.0).
  - tap_din_ready, taps_update, err_short, err_long all 0.
  - sets_loaded 0.
  - state SM_LOAD; write index 0.
- Transfer occurs when tap_din_valid=1 and tap_din_ready=1. Inputs are ignored in any other cycle, including tap_din_last.
- tap_din_ready = 1 in SM_LOAD and SM_DISCARD, and 0 in SM_WAIT_SWAP. Its first high cycle is the first clock edge after reset releases.
- SM_LOAD:
  - A transfer writes shadow[idx] = tap_din, then idx increments.
  - last=1 with idx = G_POLY_ORDER-1: go to SM_WAIT_SWAP.
  - last=1 with idx < G_POLY_ORDER-1: pulse err_short, set idx to 0, discard the shadow contents, stay in SM_LOAD.
  - last=0 with idx = G_POLY_ORDER-1: pulse err_long, set idx to 0, go to SM_DISCARD.
- SM_DISCARD: drop transfers until one carries last=1, then go to SM_LOAD with idx 0. No further error pulses in this state.
- SM_WAIT_SWAP: when swap_allow=1, copy the whole shadow bank into the active bank in one edge, increment sets_loaded, register taps_update=1, go to SM_LOAD with idx 0.
- swap_allow has no effect outside SM_WAIT_SWAP. Commits are never partial.
- enable=0 (synchronous):
  - state goes to SM_LOAD, idx to 0, ready to 0, pulses to 0.
  - Any pending or partial set is discarded.
  - Active bank and sets_loaded are retained.
- reset asserted mid-set or mid-wait: all registers, including the active bank, return immediately to their reset values.

## Timing
- Final tap transferred at cycle t:
  - t+1: SM_WAIT_SWAP, ready=0.
  - If swap_allow=1 at t+1: at t+2, taps_out holds the new set, taps_update=1, ready=1.
  - Minimum gap from a set's last tap to the next set's first tap: 2 cycles.
- If swap_allow is low at t+1, commit happens on the first cycle k with swap_allow=1. taps_out and taps_update change at k+1.
- err_short and err_long are registered: they pulse in the cycle after the offending transfer.
- Throughput within a set: 1 tap per cycle.

## Structure
- Package polynomial_pkg:
  - float_t (logic [31:0]), C_FP_DWIDTH, C_FP_ZERO.
  - The writer state_t (SM_LOAD, SM_DISCARD, SM_WAIT_SWAP).
  - The package is shared with the estimator so taps_out connects directly.
- One sub-module, polynomial_tap_bank:
  - Shadow and active register arrays, write-enable plus index, single commit strobe.
  - The state machine, counters and error logic stay in polynomial_tap_writer.

## Test plan
All cases use G_POLY_ORDER=5.
- Nominal load: send 3F800000, 40000000, 40400000, 40800000, 40A00000 (last on 5th) with swap_allow=1. Required: taps_out = {1.0,2.0,3.0,4.0,5.0} two cycles after the last tap, one taps_update pulse, sets_loaded=1.
- Held swap: same set with swap_allow=0 for 10 cycles, then 1. Required: ready=0 and taps_out unchanged throughout the hold; update lands one cycle after swap_allow rises.
- Short set: 3 taps with last on the 3rd. Required: err_short pulse, active bank unchanged. A following 5-tap set of 41000000 commits correctly.
- Long set: 7 taps with last on the 7th. Required: err_long pulse after the 5th tap, taps 6-7 dropped, no commit. The next valid set commits.
- enable=0 during SM_WAIT_SWAP with swap_allow later 1. Required: no commit and previous taps retained. After re-enable, idx starts at 0.
- Async reset pulsed mid-set. Required: taps_out = 0.0 ×5 and sets_loaded=0 immediately; ready returns 1 on the first edge after release.
